// File: rtl/axis_testpattern_if.sv
// AXI-stream style pixel bus between the test-pattern source and the video sink.
interface axis_testpattern_if;
    logic        o_valid;
    logic        i_ready;
    logic        o_hlast;
    logic        o_vlast;
    logic [23:0] o_rgb_pix;

    modport master (
        output o_valid,
        output o_hlast,
        output o_vlast,
        output o_rgb_pix,
        input  i_ready
    );

    modport slave (
        input  o_valid,
        input  o_hlast,
        input  o_vlast,
        input  o_rgb_pix,
        output i_ready
    );
endinterface

// File: rtl/axis_testpattern.sv
// Video test-pattern generator: colour bars, checkerboard, gradient, solid.
// Optional macro AXISTESTPATTERN_SCROLL_EN scrolls patterns 1 and 2 by one pixel per frame.
module axis_testpattern #(
    parameter int HW = 12,
    parameter int VW = 12
) (
    input  logic                i_pixclk,
    input  logic                i_reset,
    input  logic [HW-1:0]       i_width,
    input  logic [VW-1:0]       i_height,
    input  logic [1:0]          i_pattern,
    input  logic [23:0]         i_color,
    axis_testpattern_if.master  axis
);
    logic          start_q;
    logic          valid_q;
    logic          hlast_q, hlast_d;
    logic          vlast_q, vlast_d;
    logic [23:0]   pix_q, pix_d;
    logic [HW-1:0] x_q, x_d;
    logic [VW-1:0] y_q, y_d;
    logic [HW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [HW-1:0] w_q, w_d;
    logic [VW-1:0] h_q, h_d;
    logic [1:0]    pat_q, pat_d;
    logic [23:0]   col_q, col_d;
    logic [HW-1:0] bw;
    logic [7:0]    scroll;
    logic [7:0]    xs;
    logic          xfer, fend, load, adv;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        unique case (idx)
            3'd0: c = 24'hFFFFFF;
            3'd1: c = 24'hFFFF00;
            3'd2: c = 24'h00FFFF;
            3'd3: c = 24'h00FF00;
            3'd4: c = 24'hFF00FF;
            3'd5: c = 24'hFF0000;
            3'd6: c = 24'h0000FF;
            3'd7: c = 24'h000000;
        endcase
        return c;
    endfunction

    assign xfer = valid_q & axis.i_ready;
    assign fend = xfer & hlast_q & vlast_q;
    assign load = start_q | fend;
    assign adv  = start_q | xfer;

    assign w_d   = load ? i_width   : w_q;
    assign h_d   = load ? i_height  : h_q;
    assign pat_d = load ? i_pattern : pat_q;
    assign col_d = load ? i_color   : col_q;
    assign bw    = w_d >> 3;

`ifdef AXISTESTPATTERN_SCROLL_EN
    logic [7:0] fcnt_q, fcnt_d;

    assign fcnt_d = fend ? fcnt_q + 8'd1 : fcnt_q;
    assign scroll = fcnt_d;

    always_ff @(posedge i_pixclk) begin
        if (i_reset) fcnt_q <= '0;
        else         fcnt_q <= fcnt_d;
    end
`else
    assign scroll = 8'd0;
`endif

    // Everything below describes the beat that will be presented next.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        bcnt_d = bcnt_q;
        bidx_d = bidx_q;
        if (start_q) begin
            x_d = '0;
            y_d = '0;
        end else if (xfer) begin
            if (hlast_q) begin
                x_d = '0;
                y_d = vlast_q ? '0 : y_q + VW'(1);
            end else begin
                x_d = x_q + HW'(1);
            end
        end
        if (x_d == '0) begin
            bcnt_d = '0;
            bidx_d = '0;
        end else if (adv) begin
            if (bcnt_q == bw - HW'(1) && bidx_q != 3'd7) begin
                bcnt_d = '0;
                bidx_d = bidx_q + 3'd1;
            end else begin
                bcnt_d = bcnt_q + HW'(1);
            end
        end
    end

    assign xs      = x_d[7:0] + scroll;
    assign hlast_d = (x_d == w_d - HW'(1));
    assign vlast_d = (y_d == h_d - VW'(1));

    always_comb begin
        pix_d = '0;
        unique case (pat_d)
            2'd0: pix_d = bar_color(bidx_d);
            2'd1: pix_d = (xs[4] ^ y_d[4]) ? 24'hFFFFFF : 24'h000000;
            2'd2: pix_d = {xs, y_d[7:0], xs ^ y_d[7:0]};
            2'd3: pix_d = col_d;
        endcase
    end

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            start_q <= 1'b1;
            valid_q <= 1'b0;
            hlast_q <= 1'b0;
            vlast_q <= 1'b0;
            pix_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            bcnt_q  <= '0;
            bidx_q  <= '0;
            w_q     <= '0;
            h_q     <= '0;
            pat_q   <= '0;
            col_q   <= '0;
        end else begin
            start_q <= 1'b0;
            valid_q <= 1'b1;
            if (adv) begin
                hlast_q <= hlast_d;
                vlast_q <= vlast_d;
                pix_q   <= pix_d;
                x_q     <= x_d;
                y_q     <= y_d;
                bcnt_q  <= bcnt_d;
                bidx_q  <= bidx_d;
                w_q     <= w_d;
                h_q     <= h_d;
                pat_q   <= pat_d;
                col_q   <= col_d;
            end
        end
    end

    assign axis.o_valid   = valid_q;
    assign axis.o_hlast   = hlast_q;
    assign axis.o_vlast   = vlast_q;
    assign axis.o_rgb_pix = pix_q;
endmodule

// File: tb/tb_axis_testpattern.sv
// Directed self-checking bench for axis_testpattern.
module tb_axis_testpattern;
    logic        clk;
    logic        rst;
    logic [11:0] width;
    logic [11:0] height;
    logic [1:0]  pattern;
    logic [23:0] color;
    int          checks;
    int          fails;

    axis_testpattern_if bus ();

    axis_testpattern #(.HW(12), .VW(12)) dut (
        .i_pixclk  (clk),
        .i_reset   (rst),
        .i_width   (width),
        .i_height  (height),
        .i_pattern (pattern),
        .i_color   (color),
        .axis      (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        check("rst_valid", 32'(bus.o_valid), 0);
        check("rst_hlast", 32'(bus.o_hlast), 0);
        check("rst_vlast", 32'(bus.o_vlast), 0);
        check("rst_pix", 32'(bus.o_rgb_pix), 0);
        rst = 1'b0;
        step();
        check("first_valid", 32'(bus.o_valid), 1);
    endtask

    function automatic logic [23:0] bar_exp(input int x, input int w);
        int bi;
        logic [23:0] tbl [8];
        tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        bi = x / (w >> 3);
        if (bi > 7) bi = 7;
        return tbl[bi];
    endfunction

    function automatic logic [23:0] chk_exp(input int x, input int y);
        return (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
    endfunction

    initial begin
        checks      = 0;
        fails       = 0;
        rst         = 1'b1;
        bus.i_ready = 1'b1;

        // Line/frame markers, 32x20 solid
        width = 12'd32; height = 12'd20; pattern = 2'd3; color = 24'h123456;
        do_reset();
        for (int b = 0; b < 1280; b++) begin
            int k;
            k = b % 640;
            check("t1_hlast", 32'(bus.o_hlast), 32'(k % 32 == 31));
            check("t1_vlast", 32'(bus.o_vlast), 32'(k >= 608));
            check("t1_pix", 32'(bus.o_rgb_pix), 32'h123456);
            check("t1_valid", 32'(bus.o_valid), 1);
            step();
        end

        // Colour bars, W=64
        width = 12'd64; height = 12'd16; pattern = 2'd0;
        do_reset();
        for (int b = 0; b < 1024; b++) begin
            check("t2_bar", 32'(bus.o_rgb_pix), 32'(bar_exp(b % 64, 64)));
            step();
        end
        check("t2_p0", 32'(bus.o_rgb_pix), 32'hFFFFFF);

        // Colour bars, W=70: tail pixels use the last bar
        width = 12'd70;
        do_reset();
        for (int b = 0; b < 70; b++) begin
            check("t2b_bar", 32'(bus.o_rgb_pix), 32'(bar_exp(b, 70)));
            step();
        end

        // Backpressure at x=10 on the gradient
        width = 12'd32; height = 12'd16; pattern = 2'd2;
        do_reset();
        repeat (10) step();
        check("bp_pre", 32'(bus.o_rgb_pix), 32'h0A000A);
        bus.i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_pix", 32'(bus.o_rgb_pix), 32'h0A000A);
            check("bp_valid", 32'(bus.o_valid), 1);
            check("bp_hlast", 32'(bus.o_hlast), 0);
        end
        bus.i_ready = 1'b1;
        check("bp_rel", 32'(bus.o_rgb_pix), 32'h0A000A);
        step();
        check("bp_next", 32'(bus.o_rgb_pix), 32'h0B000B);

        // Mid-frame parameter change takes effect next frame
        width = 12'd32; height = 12'd32; pattern = 2'd3; color = 24'hABCDEF;
        do_reset();
        for (int b = 0; b < 1024; b++) begin
            if (b == 160) begin
                pattern = 2'd1;
                color   = 24'h111111;
            end
            check("mf_solid", 32'(bus.o_rgb_pix), 32'hABCDEF);
            step();
        end
        for (int b = 0; b < 1024; b++) begin
            check("mf_chk", 32'(bus.o_rgb_pix), 32'(chk_exp(b % 32, b / 32)));
            step();
        end

        // Reset in the middle of a frame
        width = 12'd32; height = 12'd20; pattern = 2'd2;
        do_reset();
        repeat (103) step();
        check("mr_at73", 32'(bus.o_rgb_pix), 32'h070304);
        rst = 1'b1;
        step();
        check("mr_valid", 32'(bus.o_valid), 0);
        check("mr_pix", 32'(bus.o_rgb_pix), 0);
        check("mr_hlast", 32'(bus.o_hlast), 0);
        check("mr_vlast", 32'(bus.o_vlast), 0);
        step();
        rst = 1'b0;
        step();
        check("mr_fvalid", 32'(bus.o_valid), 1);
        check("mr_fpix", 32'(bus.o_rgb_pix), 0);
        check("mr_fhlast", 32'(bus.o_hlast), 0);
        check("mr_fvlast", 32'(bus.o_vlast), 0);
        step();
        check("mr_x1", 32'(bus.o_rgb_pix), 32'h010001);

`ifdef AXISTESTPATTERN_SCROLL_EN
        width = 12'd16; height = 12'd16; pattern = 2'd2;
        do_reset();
        for (int f = 0; f <= 256; f++) begin
            check("sc_r", 32'(bus.o_rgb_pix[23:16]), 32'(f % 256));
            repeat (256) step();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
